axi_host_seq: RTL and testbench

- Synthesizable host-side initiator for the accelerator `top`. It is the master end of the interfaces that `top` exposes as slave/sink.
- Buffers N input characters and streams them to `top` over AXI-Stream.
- Starts `top` through an AXI-Lite write to reg0, polls reg2 until finish, then sinks the result stream into a readback buffer.
- Used on-chip in place of a PS driver and as a self-checking stimulus source.

---
 rtl/axi_host_seq.sv | 184 ++++++++++++++++++
 tb/tb_axi_host_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_host_seq.sv
// Host-side initiator: streams a loaded frame into the accelerator, starts it over AXI-Lite,
// polls its status register until finish, then captures the result stream for readback.
module axi_host_seq #(
  parameter int N                  = 32,
  parameter int CHAR_LEN           = 8,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            ld_valid,
  input  logic [CHAR_LEN-1:0]             ld_data,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  input  logic [$clog2(N)-1:0]            rd_addr,
  output logic [CHAR_LEN-1:0]             rd_data,
  output logic [$clog2(N):0]              rx_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [CHAR_LEN-1:0]             M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  input  logic [CHAR_LEN-1:0]             S_AXIS_TDATA,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY
);
  localparam int PW = $clog2(N);
  localparam logic [PW:0] NMAX = N[PW:0];
  localparam logic [PW:0] ONE  = {{PW{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_SEND, S_AW, S_B, S_AR, S_R, S_WAIT, S_RECV, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW:0]         ptr_q, idx_q, rx_cnt_q;
  logic                aw_ok_q, w_ok_q, err_q;
  logic [1:0]          wait_q;
  logic [CHAR_LEN-1:0] rd_data_q;
  logic [CHAR_LEN-1:0] buf_in  [N];
  logic [CHAR_LEN-1:0] buf_out [N];

  logic ld_en, st_en, start_go, snd_hs, snd_last;
  logic aw_hs, w_hs, aw_all, w_all, b_hs, ar_hs, r_hs, rx_hs;
  logic unused_rdata;

  assign ld_en    = (state_q == S_IDLE) && ld_valid && (ptr_q < NMAX);
  assign start_go = (state_q == S_IDLE) && start;
  assign snd_last = (idx_q == ptr_q - ONE);
  assign snd_hs   = M_AXIS_TVALID && M_AXIS_TREADY;
  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
  assign aw_all   = aw_ok_q || aw_hs;
  assign w_all    = w_ok_q || w_hs;
  assign b_hs     = M_AXI_BVALID && M_AXI_BREADY;
  assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs     = M_AXI_RVALID && M_AXI_RREADY;
  assign rx_hs    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign st_en    = rx_hs && (rx_cnt_q < NMAX);
  assign unused_rdata = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:1];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (ptr_q == '0) ? S_DONE : S_SEND;
      S_SEND: if (snd_hs && snd_last) state_d = S_AW;
      S_AW:   if (aw_all && w_all) state_d = S_B;
      S_B:    if (b_hs) state_d = (M_AXI_BRESP != 2'b00) ? S_DONE : S_AR;
      S_AR:   if (ar_hs) state_d = S_R;
      S_R: begin
        if (r_hs) begin
          if (M_AXI_RRESP != 2'b00) state_d = S_DONE;
          else if (M_AXI_RDATA[0])  state_d = S_RECV;
          else                      state_d = S_WAIT;
        end
      end
      S_WAIT: if (wait_q == 2'd3) state_d = S_AR;
      S_RECV: if (rx_hs && S_AXIS_TLAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All bus strobes decode from registered state, so reset drops them without waiting for a clock.
  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    done          = (state_q == S_DONE);
    err           = err_q;
    rd_data       = rd_data_q;
    rx_count      = rx_cnt_q;
    M_AXIS_TVALID = (state_q == S_SEND);
    M_AXIS_TDATA  = buf_in[idx_q[PW-1:0]];
    M_AXIS_TLAST  = (state_q == S_SEND) && snd_last;
    M_AXI_AWADDR  = '0;
    M_AXI_AWPROT  = 3'b000;
    M_AXI_AWVALID = (state_q == S_AW) && !aw_ok_q;
    M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(3);
    M_AXI_WSTRB   = '1;
    M_AXI_WVALID  = (state_q == S_AW) && !w_ok_q;
    M_AXI_BREADY  = (state_q == S_B);
    M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(8);
    M_AXI_ARPROT  = 3'b000;
    M_AXI_ARVALID = (state_q == S_AR);
    M_AXI_RREADY  = (state_q == S_R);
    S_AXIS_TREADY = (state_q == S_RECV);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr_q    <= '0;
      idx_q    <= '0;
      rx_cnt_q <= '0;
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (ld_en) ptr_q <= ptr_q + ONE;
      if (start_go) begin
        err_q    <= (ptr_q == '0);
        rx_cnt_q <= '0;
        idx_q    <= '0;
      end
      if (snd_hs) begin
        if (snd_last) begin
          idx_q <= '0;
          ptr_q <= '0;
        end else begin
          idx_q <= idx_q + ONE;
        end
      end
      // Each write channel is tracked separately; both flags clear once the pair completes.
      if (state_q == S_AW) begin
        if (aw_all && w_all) begin
          aw_ok_q <= 1'b0;
          w_ok_q  <= 1'b0;
        end else begin
          if (aw_hs) aw_ok_q <= 1'b1;
          if (w_hs)  w_ok_q  <= 1'b1;
        end
      end
      if (b_hs && (M_AXI_BRESP != 2'b00)) err_q <= 1'b1;
      if (r_hs && (M_AXI_RRESP != 2'b00)) err_q <= 1'b1;
      if (state_q == S_WAIT) wait_q <= wait_q + 2'd1;
      if (rx_hs) begin
        if (st_en) rx_cnt_q <= rx_cnt_q + ONE;
        else       err_q    <= 1'b1;
      end
    end
  end

  // Frame buffers keep their contents across reset.
  always_ff @(posedge ACLK) begin
    if (ld_en) buf_in[ptr_q[PW-1:0]] <= ld_data;
    if (st_en) buf_out[rx_cnt_q[PW-1:0]] <= S_AXIS_TDATA;
    rd_data_q <= buf_out[rd_addr];
  end
endmodule

// File: tb/tb_axi_host_seq.sv
// Directed bench for axi_host_seq with a stream/AXI-Lite model of the accelerator.
module tb_axi_host_seq;
  localparam int N  = 32;
  localparam int PW = $clog2(N);

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic          ld_valid, start, busy, done, err;
  logic [7:0]    ld_data, rd_data;
  logic [PW-1:0] rd_addr;
  logic [PW:0]   rx_count;
  logic [3:0]    AWADDR, ARADDR, WSTRB;
  logic [2:0]    AWPROT, ARPROT;
  logic [31:0]   WDATA, RDATA;
  logic [1:0]    BRESP, RRESP;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RREADY;
  logic [7:0] M_TDATA, S_TDATA;
  logic M_TLAST, M_TVALID, M_TREADY, S_TLAST, S_TVALID, S_TREADY;

  axi_host_seq #(.N(N), .CHAR_LEN(8), .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ld_valid(ld_valid), .ld_data(ld_data), .start(start),
    .busy(busy), .done(done), .err(err), .rd_addr(rd_addr), .rd_data(rd_data), .rx_count(rx_count),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .M_AXIS_TDATA(M_TDATA), .M_AXIS_TLAST(M_TLAST), .M_AXIS_TVALID(M_TVALID), .M_AXIS_TREADY(M_TREADY),
    .S_AXIS_TDATA(S_TDATA), .S_AXIS_TLAST(S_TLAST), .S_AXIS_TVALID(S_TVALID), .S_AXIS_TREADY(S_TREADY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];

  bit         tog_en = 1'b0;
  bit         aw_dly = 1'b0;
  int         polls_cfg = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int         res_n = 0;
  int         frame_id = 0;

  int  seen_id = -1;
  int  res_idx, aw_cnt, w_cnt, b_cnt, ar_cnt, polls_left, w_cyc, r_cyc;
  int  done_cnt = 0;
  bit  aw_seen, w_seen, b_issued, r_seen, stall;
  bit  m_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, s_fire;
  logic [8:0] stall_val, e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accelerator model: acts on the cycle before each rising edge, so every handshake it
  // records here completes on the following edge.
  always @(negedge ACLK) begin
    cyc++;
    if (!ARESETN || frame_id != seen_id) begin
      seen_id = frame_id;
      aw_seen = 0; w_seen = 0; b_issued = 0; r_seen = 0; stall = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; res_idx = 0;
      polls_left = polls_cfg;
      BVALID = 0; BRESP = 2'b00; RVALID = 0; RDATA = '0; RRESP = 2'b00;
      m_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0; s_fire = 0;
    end else begin
      if (w_fire) begin w_seen = 1; w_cyc = cyc; end
      if (aw_fire) aw_seen = 1;
      if (b_fire) BVALID = 0;
      if (r_fire) RVALID = 0;
      if (ar_fire) begin
        RVALID = 1; RRESP = 2'b00;
        RDATA = (polls_left > 0) ? 32'h0 : 32'h1;
        if (polls_left > 0) polls_left--;
      end
      if (s_fire) res_idx++;
      if (aw_seen && w_seen && !b_issued) begin
        BVALID = 1; BRESP = bresp_cfg; b_issued = 1;
      end
      if (stall) chk("tdata_stable", 64'({M_TVALID, M_TLAST, M_TDATA}), 64'({1'b1, stall_val}));
      if (BREADY) chk("bready_after_both", 64'({aw_seen, w_seen}), 64'(2'b11));
      if (w_seen && !aw_seen) begin
        chk("wvalid_dropped", 64'(WVALID), 64'(0));
        chk("awvalid_held", 64'(AWVALID), 64'(1));
      end
    end
    M_TREADY = tog_en ? ~M_TREADY : 1'b1;
    WREADY   = WVALID;
    AWREADY  = AWVALID && (!aw_dly || (w_seen && (cyc - w_cyc >= 3)));
    ARREADY  = ARVALID;
    S_TVALID = (res_idx < res_n);
    S_TDATA  = res_idx[7:0];
    S_TLAST  = (res_idx == res_n - 1);

    m_fire  = M_TVALID && M_TREADY;
    aw_fire = AWVALID && AWREADY;
    w_fire  = WVALID && WREADY;
    b_fire  = BVALID && BREADY;
    ar_fire = ARVALID && ARREADY;
    r_fire  = RVALID && RREADY;
    s_fire  = S_TVALID && S_TREADY;
    stall     = M_TVALID && !M_TREADY;
    stall_val = {M_TLAST, M_TDATA};

    if (m_fire) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("in_beat", 64'({M_TLAST, M_TDATA}), 64'(e));
      end
    end
    if (aw_fire) begin
      aw_cnt++;
      chk("awaddr", 64'({AWPROT, AWADDR}), 64'(0));
    end
    if (w_fire) begin
      w_cnt++;
      chk("wdata", 64'({WSTRB, WDATA}), 64'({4'hF, 32'h3}));
    end
    if (b_fire) b_cnt++;
    if (ar_fire) begin
      ar_cnt++;
      chk("araddr", 64'({ARPROT, ARADDR}), 64'(8));
      if (r_seen) chk("poll_gap", 64'(cyc - r_cyc), 64'(5));
    end
    if (r_fire) begin r_seen = 1; r_cyc = cyc; end
    if (done) done_cnt++;
  end

  task automatic load_frame(input int n, input bit basic);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = basic ? ((i == n - 1) ? 8'hFF : 8'h01) : 8'($urandom_range(255));
      ld_valid = 1'b1; ld_data = d;
      @(negedge ACLK);
      exp_q.push_back({(i == n - 1), d});
    end
    ld_valid = 1'b0;
  endtask

  task automatic start_frame(output int d0);
    frame_id++;
    @(negedge ACLK);
    d0 = done_cnt;
    start = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input bit exp_err, input int exp_rx, input int d0);
    int k;
    k = 0;
    while (!done && k < 3000) begin @(negedge ACLK); k++; end
    chk("done_seen", 64'(done), 64'(1));
    chk("err_at_done", 64'(err), 64'(exp_err));
    repeat (4) @(negedge ACLK);
    chk("single_done", 64'(done_cnt - d0), 64'(1));
    chk("rx_count", 64'(rx_count), 64'(exp_rx));
    chk("all_sent_once", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic rd_check(input int a, input logic [7:0] exp);
    rd_addr = a[PW-1:0];
    @(negedge ACLK);
    chk("rd_data", 64'(rd_data), 64'(exp));
  endtask

  initial begin
    int d0, k;
    ld_valid = 0; ld_data = 0; start = 0; rd_addr = 0; ARESETN = 0;
    repeat (3) @(negedge ACLK);
    chk("reset_outputs", 64'({busy, done, err, M_TVALID, AWVALID, WVALID, BREADY, ARVALID, RREADY, S_TREADY}), 64'(0));
    chk("reset_rx_count", 64'(rx_count), 64'(0));
    ARESETN = 1;
    @(negedge ACLK);

    // empty buffer: immediate done with error, no traffic
    start = 1; @(negedge ACLK); start = 0;
    chk("empty_done", 64'({done, err, busy}), 64'(3'b110));
    @(negedge ACLK);
    chk("empty_done_pulse", 64'({done, err}), 64'(2'b01));
    chk("empty_no_bus", 64'(aw_cnt + w_cnt + ar_cnt), 64'(0));

    // basic frame
    polls_cfg = 2; res_n = N;
    load_frame(N, 1'b1);
    start_frame(d0);
    wait_done(1'b0, N, d0);
    chk("basic_aw_w_b", 64'({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt)}), 64'(24'h010101));
    chk("basic_ar", 64'(ar_cnt), 64'(3));
    rd_check(5, 8'h05);
    rd_check(0, 8'h00);
    rd_check(31, 8'h1F);

    // backpressure on the stream, AWREADY lagging WREADY
    tog_en = 1; aw_dly = 1; polls_cfg = 0;
    load_frame(N, 1'b0);
    start_frame(d0);
    wait_done(1'b0, N, d0);
    chk("bp_aw_w_b", 64'({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt)}), 64'(24'h010101));
    chk("bp_ar", 64'(ar_cnt), 64'(1));
    tog_en = 0; aw_dly = 0;

    // three not-finished polls
    polls_cfg = 3;
    load_frame(4, 1'b0);
    start_frame(d0);
    wait_done(1'b0, N, d0);
    chk("poll_ar_count", 64'(ar_cnt), 64'(4));

    // write error response
    polls_cfg = 0; bresp_cfg = 2'b10;
    load_frame(3, 1'b0);
    start_frame(d0);
    wait_done(1'b1, 0, d0);
    chk("bresp_no_ar", 64'(ar_cnt), 64'(0));
    bresp_cfg = 2'b00;

    // result stream overflow
    res_n = N + 2;
    load_frame(6, 1'b0);
    start_frame(d0);
    wait_done(1'b1, N, d0);
    rd_check(31, 8'h1F);
    res_n = N;

    // start and load while busy are ignored
    polls_cfg = 2;
    load_frame(5, 1'b0);
    start_frame(d0);
    k = 0;
    while (!ARVALID && k < 500) begin @(negedge ACLK); k++; end
    chk("reached_poll", 64'(ARVALID), 64'(1));
    ld_valid = 1; ld_data = 8'hAA; start = 1;
    @(negedge ACLK);
    ld_valid = 0; start = 0;
    wait_done(1'b0, N, d0);
    chk("busy_ar_count", 64'(ar_cnt), 64'(3));
    frame_id++;
    @(negedge ACLK);
    start = 1; @(negedge ACLK); start = 0;
    chk("ignored_load_empty", 64'({done, err}), 64'(2'b11));
    repeat (3) @(negedge ACLK);
    chk("ignored_load_no_bus", 64'(aw_cnt), 64'(0));

    // reset in the middle of the result stream
    polls_cfg = 0; res_n = N;
    load_frame(8, 1'b0);
    start_frame(d0);
    k = 0;
    while (rx_count < 10 && k < 1000) begin @(negedge ACLK); k++; end
    chk("reached_recv", 64'(S_TREADY), 64'(1));
    #2 ARESETN = 0;
    #1;
    chk("async_reset_outputs", 64'({busy, done, M_TVALID, AWVALID, WVALID, BREADY, ARVALID, RREADY, S_TREADY}), 64'(0));
    chk("async_reset_rx", 64'(rx_count), 64'(0));
    res_n = 0;
    #7 ARESETN = 1;
    repeat (6) @(negedge ACLK);
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'(0));

    res_n = N;
    load_frame(N, 1'b1);
    start_frame(d0);
    wait_done(1'b0, N, d0);
    rd_check(17, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
